nibble_serial_adder_ctrl: RTL and testbench

Sequencer that performs a wide add or subtract by time-multiplexing a single `fourbit_adder` slice over successive nibbles. It chains the carry through a register, one nibble per clock. It sits between a requesting client and the shared 4-bit adder datapath and exposes a start/busy/done handshake. The result is held stable until the next accepted request.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 12 +
 rtl/nibble_serial_adder_ctrl_if.sv | 29 ++
 rtl/fourbit_adder.sv | 12 +
 rtl/nibble_serial_adder_ctrl.sv | 107 ++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Client-facing start/busy/done handshake and operand/result bus.
interface nibble_serial_adder_ctrl_if
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
);
  localparam int W = NIBBLE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/fourbit_adder.sv
// Shared 4-bit adder slice with carry in and carry out.
module fourbit_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequenced one nibble per clock through a single adder slice.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_adder_ctrl_if.slave  bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef logic [NIBBLES-1:0][NIBBLE_W-1:0] word_t;

  state_e             state_q, state_d;
  word_t              a_q, a_d;
  word_t              b_q, b_d;
  word_t              acc_q, acc_d;
  logic [W-1:0]       sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_carry;

  fourbit_adder u_slice (
    .a     (a_q[idx_q]),
    .b     (b_q[idx_q]),
    .cin   (carry_q),
    .sum   (slice_sum),
    .carry (slice_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          // Subtraction is A + ~B + 1, so the slice never needs to know the mode.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub | bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q] = slice_sum;
        carry_d      = slice_carry;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = slice_carry;
          ovf_d   = (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                    (slice_sum[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl: directed cases plus random requests.
module tb_nibble_serial_adder_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   cyc      = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Reference: plain modulo arithmetic, unsigned compare for borrow, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    exp_t         e;
    logic [W:0]   full;
    int           sr;
    if (s) begin
      e.sum  = a - b;
      e.cout = (a >= b);
      sr     = int'($signed(a)) - int'($signed(b));
    end else begin
      full   = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      e.sum  = full[W-1:0];
      e.cout = full[W];
      sr     = int'($signed(a)) + int'($signed(b)) + int'(c);
    end
    e.ovf = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    e.cyc = 0;
    e.tag = "";
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        fail_now("unexpected_done");
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_sum"},  bus.sum,      e.sum);
        chk({e.tag, "_cout"}, bus.cout,     e.cout);
        chk({e.tag, "_ovf"},  bus.overflow, e.ovf);
        chk({e.tag, "_cyc"},  cyc,          e.cyc);
        chk({e.tag, "_busy"}, bus.busy,     1'b0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) fail_now("wait_ready");
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail_now("wait_drain");
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input string tag);
    exp_t e;
    wait_ready();
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    bus.sub   = s;
    e         = model(a, b, c, s);
    e.cyc     = cyc + 1 + NIBBLES;
    e.tag     = tag;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.cin   = 1'($urandom);
    bus.sub   = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   d0;
    int   k;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_sum",  bus.sum,  '0);
    chk("rst_cout", bus.cout, 1'b0);
    chk("rst_ovf",  bus.overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, "add");
    chk("add_busy_run", bus.busy, 1'b1);
    wait_drain();
    @(negedge clk);
    chk("add_done_pulse", bus.done, 1'b0);
    chk("add_sum_held",   bus.sum,  16'h5555);

    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_wrap");
    wait_drain();
    issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf");
    wait_drain();
    issue(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_borrow");
    wait_drain();
    issue(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
    wait_drain();

    d0 = done_cnt;
    issue(16'h1111, 16'h2222, 1'b1, 1'b0, "ign_start");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hABCD;
    bus.b     = 16'h0F0F;
    bus.sub   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);
    chk("ign_done_count", done_cnt - d0, 1);

    issue(16'h3C3C, 16'h1234, 1'b0, 1'b0, "aborted");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_done", bus.done, 1'b0);
    chk("abort_sum",  bus.sum,  '0);
    chk("abort_cout", bus.cout, 1'b0);
    chk("abort_ovf",  bus.overflow, 1'b0);
    e = sb.pop_back();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(16'h0F0F, 16'hF0F0, 1'b0, 1'b0, "post_rst");
    wait_drain();

    wait_ready();
    k         = cyc + 1;
    bus.start = 1'b1;
    bus.a     = 16'h0001;
    bus.b     = 16'h0001;
    bus.cin   = 1'b0;
    bus.sub   = 1'b0;
    e = model(16'h0001, 16'h0001, 1'b0, 1'b0);
    e.cyc = k + NIBBLES;
    e.tag = "b2b_first";
    sb.push_back(e);
    @(negedge clk);
    bus.a = 16'h00FF;
    bus.b = 16'h0001;
    e = model(16'h00FF, 16'h0001, 1'b0, 1'b0);
    e.cyc = k + 2 * NIBBLES + 1;
    e.tag = "b2b_second";
    sb.push_back(e);
    repeat (NIBBLES + 1) @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    for (int i = 0; i < 30; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
